// File: rtl/sb_crc_rx_ctrl.sv
// Purpose     : USB4 sideband receive sequencer; frames 10-bit symbols, hunts DLE/STX..DLE/ETX,
//               unstuffs DLE and replays covered bytes bit-serially into an external CRC-16 engine.
// Latency     : every output reacts the cycle after the symbol-completing clock edge;
//               STX replay is delayed one more cycle behind its crc_init pulse.
// Backpressure: none; rx_valid gaps hold all state, and a byte replay (8 cycles)
//               always finishes before the next 10-bit symbol can complete.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   rx_valid, rx_bit    : one serial sideband bit per valid cycle
//   crc_init            : one-cycle pulse, engine preloads 16'hFFFF
//   crc_en, crc_bit     : engine shifts crc_bit while crc_en is high
//   crc_residue         : engine register, sampled only while crc_en is low
//   pkt_done            : one-cycle pulse at transaction end, qualified by pkt_ok / crc_err
//   frame_err           : one-cycle pulse on any framing/protocol abort
//   byte_cnt            : unstuffed data bytes of the last good-framed packet
//   err_cnt (optional)  : present only when SB_CRC_ERR_CNT_EN is defined; saturating count of
//                         crc_err completions plus frame_err pulses, cleared only by reset
module sb_crc_rx_ctrl #(
    parameter logic [7:0] DLE_SYM   = 8'hFE,
    parameter logic [7:0] STX_SYM   = 8'h05,
    parameter logic [7:0] ETX_SYM   = 8'h40,
    parameter int         MAX_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic        rx_bit,
    output logic        crc_init,
    output logic        crc_en,
    output logic        crc_bit,
    input  logic [15:0] crc_residue,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        crc_err,
    output logic        frame_err,
    output logic [6:0]  byte_cnt
`ifdef SB_CRC_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_STX,
        ST_DATA,
        ST_ESC,
        ST_CHECK
    } state_t;

    localparam logic [6:0] MAX_PUSH = 7'(MAX_BYTES);
    // Replay counter: 9 = crc_init slot ahead of the STX replay, 8..1 = bit being shifted out.
    localparam logic [3:0] REP_PRE  = 4'd9;
    localparam logic [3:0] REP_LEN  = 4'd8;
    localparam logic [3:0] LAST_BIT = 4'd9;

    // Symbol framer
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q,   shift_d;

    // Transaction FSM and two-byte delay line (hold0 older, hold1 newer)
    state_t     state_q,    state_d;
    logic [7:0] hold0_q,    hold0_d;
    logic [7:0] hold1_q,    hold1_d;
    logic [1:0] held_q,     held_d;
    logic [6:0] push_cnt_q, push_cnt_d;
    logic [6:0] data_cnt_q, data_cnt_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;

    // Replay shifter and registered pulses
    logic [7:0] rep_sr_q,   rep_sr_d;
    logic [3:0] rep_cnt_q,  rep_cnt_d;
    logic       crc_init_q, crc_init_d;
    logic       frame_err_q, frame_err_d;

    logic       sym_bad;
    logic       sym_ok;
    logic       start_pkt;
    logic       do_push;
    logic [7:0] push_byte;
    logic       crc_match;

    // Framing decode of the current bit: bad start bit, bad stop bit, or a good completed symbol.
    always_comb begin
        sym_bad = 1'b0;
        sym_ok  = 1'b0;
        if (rx_valid) begin
            if (bit_cnt_q == 4'd0) begin
                sym_bad = rx_bit;
            end else if (bit_cnt_q == LAST_BIT) begin
                sym_bad = ~rx_bit;
                sym_ok  = rx_bit;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        held_d      = held_q;
        push_cnt_d  = push_cnt_q;
        data_cnt_d  = data_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rep_sr_d    = rep_sr_q;
        rep_cnt_d   = rep_cnt_q;
        crc_init_d  = 1'b0;
        frame_err_d = 1'b0;
        start_pkt   = 1'b0;
        do_push     = 1'b0;
        push_byte   = shift_q;

        // Replay shifter runs free; the pre slot (9) only burns the crc_init cycle.
        if (rep_cnt_q != 4'd0) begin
            rep_cnt_d = rep_cnt_q - 4'd1;
            if (rep_cnt_q <= REP_LEN) begin
                rep_sr_d = {1'b0, rep_sr_q[7:1]};
            end
        end

        // Framer: bit counter resyncs to 0 on a bad start bit and after every stop bit.
        if (rx_valid) begin
            if (bit_cnt_q == LAST_BIT || sym_bad) begin
                bit_cnt_d = 4'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd8) begin
                shift_d = {rx_bit, shift_q[7:1]};
            end
        end

        // CHECK only exists for the single pkt_done cycle.
        if (state_q == ST_CHECK) begin
            state_d = ST_IDLE;
        end

        if (sym_bad) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
        end else if (sym_ok) begin
            case (state_q)
                ST_IDLE: begin
                    if (shift_q == DLE_SYM) begin
                        state_d = ST_WAIT_STX;
                    end
                end
                ST_WAIT_STX: begin
                    if (shift_q == STX_SYM) begin
                        start_pkt = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (shift_q == DLE_SYM) begin
                        state_d = ST_ESC;
                    end else begin
                        do_push = 1'b1;
                    end
                end
                ST_ESC: begin
                    if (shift_q == DLE_SYM) begin
                        do_push   = 1'b1;
                        push_byte = DLE_SYM;
                        state_d   = ST_DATA;
                    end else if (shift_q == ETX_SYM) begin
                        // The two held bytes are the CRC field; anything less is malformed.
                        if (held_q == 2'd2) begin
                            state_d    = ST_CHECK;
                            byte_cnt_d = data_cnt_q;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end else if (shift_q == STX_SYM) begin
                        // Nested STX abandons the current packet and starts a fresh one.
                        frame_err_d = 1'b1;
                        start_pkt   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (start_pkt) begin
            crc_init_d = 1'b1;
            rep_sr_d   = STX_SYM;
            rep_cnt_d  = REP_PRE;
            held_d     = 2'd0;
            push_cnt_d = 7'd0;
            data_cnt_d = 7'd0;
            state_d    = ST_DATA;
        end

        // Delay line: the newest two bytes may be the CRC, so only older bytes get replayed.
        if (do_push) begin
            if (push_cnt_q == MAX_PUSH) begin
                frame_err_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                push_cnt_d = push_cnt_q + 7'd1;
                if (held_q == 2'd2) begin
                    rep_sr_d   = hold0_q;
                    rep_cnt_d  = REP_LEN;
                    data_cnt_d = data_cnt_q + 7'd1;
                    hold0_d    = hold1_q;
                    hold1_d    = push_byte;
                end else if (held_q == 2'd1) begin
                    hold1_d = push_byte;
                    held_d  = 2'd2;
                end else begin
                    hold0_d = push_byte;
                    held_d  = 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            hold0_q     <= 8'd0;
            hold1_q     <= 8'd0;
            held_q      <= 2'd0;
            push_cnt_q  <= 7'd0;
            data_cnt_q  <= 7'd0;
            byte_cnt_q  <= 7'd0;
            rep_sr_q    <= 8'd0;
            rep_cnt_q   <= 4'd0;
            crc_init_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            held_q      <= held_d;
            push_cnt_q  <= push_cnt_d;
            data_cnt_q  <= data_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rep_sr_q    <= rep_sr_d;
            rep_cnt_q   <= rep_cnt_d;
            crc_init_q  <= crc_init_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Received CRC is transmitted high byte first, so the older held byte is the MSB half.
    assign crc_match = (crc_residue == {hold0_q, hold1_q});

    assign crc_init  = crc_init_q;
    assign crc_en    = (rep_cnt_q != 4'd0) && (rep_cnt_q <= REP_LEN);
    assign crc_bit   = crc_en & rep_sr_q[0];
    assign pkt_done  = (state_q == ST_CHECK);
    assign pkt_ok    = pkt_done & crc_match;
    assign crc_err   = pkt_done & ~crc_match;
    assign frame_err = frame_err_q;
    assign byte_cnt  = byte_cnt_q;

`ifdef SB_CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // frame_err and pkt_done never coincide, so one increment per cycle is enough.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((frame_err_q || crc_err) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sb_crc_rx_ctrl.sv
`timescale 1ns/1ps
module tb_sb_crc_rx_ctrl;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic        rx_bit;
    logic        crc_init, crc_en, crc_bit;
    logic [15:0] crc_residue;
    logic        pkt_done, pkt_ok, crc_err, frame_err;
    logic [6:0]  byte_cnt;
`ifdef SB_CRC_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gap_mode = 0;
    logic [15:0] eng = 16'h0000;

    sb_crc_rx_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_bit      (rx_bit),
        .crc_init    (crc_init),
        .crc_en      (crc_en),
        .crc_bit     (crc_bit),
        .crc_residue (crc_residue),
        .pkt_done    (pkt_done),
        .pkt_ok      (pkt_ok),
        .crc_err     (crc_err),
        .frame_err   (frame_err),
        .byte_cnt    (byte_cnt)
`ifdef SB_CRC_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CRC-16 (reflected 0xA001, init FFFF), bits consumed LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // External engine stand-in.
    always @(posedge clk) begin
        if (crc_init)    eng <= 16'hFFFF;
        else if (crc_en) eng <= (eng[0] ^ crc_bit) ? ((eng >> 1) ^ 16'hA001) : (eng >> 1);
    end
    assign crc_residue = eng;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model: expected outputs keyed by cycle ----------------
    bit         s_init[int];
    bit         s_en[int];
    bit         s_bit[int];
    bit         s_done[int];
    bit         s_ok[int];
    bit         s_ferr[int];
    logic [6:0] s_cnt[int];
    int         mst = 0;          // 0 hunt DLE, 1 expect STX, 2 in packet, 3 after DLE in packet
    bq_t        pl;               // unstuffed bytes pushed since STX

    task automatic sched_replay(input logic [7:0] b, input int t);
        for (int i = 0; i < 8; i++) begin
            s_en[t + i]  = 1'b1;
            s_bit[t + i] = b[i];
        end
    endtask

    task automatic m_start(input int e);
        s_init[e] = 1'b1;
        sched_replay(8'h05, e + 1);
        pl.delete();
        mst = 2;
    endtask

    task automatic m_push(input logic [7:0] b, input int e, output bit ok);
        ok = 1'b1;
        if (pl.size() == 64) begin
            s_ferr[e] = 1'b1;
            mst = 0;
            ok = 1'b0;
        end else begin
            if (pl.size() >= 2) sched_replay(pl[pl.size() - 2], e);
            pl.push_back(b);
        end
    endtask

    task automatic model_sym(input logic [7:0] b, input bit stop_ok, input int e);
        bit ok;
        logic [15:0] c;
        int n;
        if (!stop_ok) begin
            s_ferr[e] = 1'b1;
            mst = 0;
            return;
        end
        case (mst)
            0: if (b == 8'hFE) mst = 1;
            1: if (b == 8'h05) m_start(e); else mst = 0;
            2: if (b == 8'hFE) mst = 3; else m_push(b, e, ok);
            default: begin
                if (b == 8'hFE) begin
                    m_push(b, e, ok);
                    if (ok) mst = 2;
                end else if (b == 8'h40) begin
                    n = pl.size();
                    if (n < 2) begin
                        s_ferr[e] = 1'b1;
                    end else begin
                        c = crc_byte(16'hFFFF, 8'h05);
                        for (int i = 0; i < n - 2; i++) c = crc_byte(c, pl[i]);
                        s_done[e] = 1'b1;
                        s_ok[e]   = (c == {pl[n - 2], pl[n - 1]});
                        s_cnt[e]  = 7'(n - 2);
                    end
                    mst = 0;
                end else if (b == 8'h05) begin
                    s_ferr[e] = 1'b1;
                    m_start(e);
                end else begin
                    s_ferr[e] = 1'b1;
                    mst = 0;
                end
            end
        endcase
    endtask

    // ---------------- per-cycle compare ----------------
    bit         chk_on = 1'b0;
    int         n_init = 0, n_en = 0, n_done = 0, n_ferr = 0;
    bit         last_ok = 1'b0, last_cerr = 1'b0;
    logic [6:0] exp_bc = 7'd0;
    int         exp_err = 0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_bc  = 7'd0;
            exp_err = 0;
        end else if (chk_on) begin
            bit ei, ee, eb, ed, eo, ef;
            ei = s_init.exists(cyc) ? s_init[cyc] : 1'b0;
            ee = s_en.exists(cyc)   ? s_en[cyc]   : 1'b0;
            eb = s_bit.exists(cyc)  ? s_bit[cyc]  : 1'b0;
            ed = s_done.exists(cyc) ? s_done[cyc] : 1'b0;
            eo = s_ok.exists(cyc)   ? s_ok[cyc]   : 1'b0;
            ef = s_ferr.exists(cyc) ? s_ferr[cyc] : 1'b0;
            if (ed) exp_bc = s_cnt[cyc];
            chk("crc_init", 32'(crc_init), 32'(ei));
            chk("crc_en", 32'(crc_en), 32'(ee));
            if (ee) chk("crc_bit", 32'(crc_bit), 32'(eb));
            chk("pkt_done", 32'(pkt_done), 32'(ed));
            chk("pkt_ok", 32'(pkt_ok), 32'(ed & eo));
            chk("crc_err", 32'(crc_err), 32'(ed & ~eo));
            chk("frame_err", 32'(frame_err), 32'(ef));
            chk("byte_cnt", 32'(byte_cnt), 32'(exp_bc));
`ifdef SB_CRC_ERR_CNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
            if ((ef || (ed && !eo)) && exp_err < 255) exp_err++;
            s_init.delete(cyc); s_en.delete(cyc); s_bit.delete(cyc);
            s_done.delete(cyc); s_ok.delete(cyc); s_ferr.delete(cyc); s_cnt.delete(cyc);
            n_init += int'(crc_init);
            n_en   += int'(crc_en);
            n_ferr += int'(frame_err);
            if (pkt_done) begin
                n_done++;
                last_ok   = pkt_ok;
                last_cerr = crc_err;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_sym(input logic [7:0] b, input bit stop_ok = 1'b1, input int nbits = 10);
        logic [9:0] s;
        s = {stop_ok, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            int g;
            g = (gap_mode == 1) ? 2 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
            repeat (g) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_bit   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_bit   = s[k];
            if (k == 9) model_sym(b, stop_ok, cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_stuffed(input logic [7:0] b);
        send_sym(b);
        if (b == 8'hFE) send_sym(b);
    endtask

    task automatic send_body(input bq_t pay, input logic [7:0] xlo);
        logic [15:0] c;
        c = crc_byte(16'hFFFF, 8'h05);
        foreach (pay[i]) c = crc_byte(c, pay[i]);
        foreach (pay[i]) send_stuffed(pay[i]);
        send_stuffed(c[15:8]);
        send_stuffed(c[7:0] ^ xlo);
        send_sym(8'hFE);
        send_sym(8'h40);
    endtask

    task automatic send_pkt(input bq_t pay, input logic [7:0] xlo);
        send_sym(8'hFE);
        send_sym(8'h05);
        send_body(pay, xlo);
    endtask

    int b_init, b_en, b_done, b_ferr;
    task automatic mark();
        b_init = n_init; b_en = n_en; b_done = n_done; b_ferr = n_ferr;
    endtask

    initial begin
        bq_t q;
        logic [15:0] c;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_crc_init", 32'(crc_init), 0);
        chk("rst_crc_en", 32'(crc_en), 0);
        chk("rst_pkt_done", 32'(pkt_done), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_byte_cnt", 32'(byte_cnt), 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        chk_on = 1'b1;

        // Pin the model CRC to the published check value of this polynomial.
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = crc_byte(c, 8'(8'h31 + i));
        chk("crc_model_pin", 32'(c), 32'h4B37);

        // Clean packet
        mark(); q = {8'h12, 8'h34}; send_pkt(q, 8'h00); idle(12);
        chk("clean_init", n_init - b_init, 1);
        chk("clean_en", n_en - b_en, 24);
        chk("clean_done", n_done - b_done, 1);
        chk("clean_ok", 32'(last_ok), 1);
        chk("clean_byte_cnt", 32'(byte_cnt), 2);

        // Corrupted CRC low byte
        mark(); send_pkt(q, 8'h01); idle(12);
        chk("badcrc_done", n_done - b_done, 1);
        chk("badcrc_err", 32'(last_cerr), 1);
        chk("badcrc_ok", 32'(last_ok), 0);
`ifdef SB_CRC_ERR_CNT_EN
        chk("badcrc_err_cnt", 32'(err_cnt), 1);
`endif

        // Stuffed FE payload
        mark(); q = {8'hFE}; send_pkt(q, 8'h00); idle(12);
        chk("stuff_en", n_en - b_en, 16);
        chk("stuff_byte_cnt", 32'(byte_cnt), 1);
        chk("stuff_ok", 32'(last_ok), 1);

        // Bad stop bit in third data symbol, then a clean packet
        mark();
        send_sym(8'hFE); send_sym(8'h05); send_sym(8'h11); send_sym(8'h22); send_sym(8'h33, 1'b0);
        idle(12);
        chk("stop_ferr", n_ferr - b_ferr, 1);
        chk("stop_no_done", n_done - b_done, 0);
        mark(); q = {8'hA5, 8'h5A}; send_pkt(q, 8'h00); idle(12);
        chk("after_stop_ok", 32'(last_ok), 1);
        chk("after_stop_done", n_done - b_done, 1);

        // Only one held byte before ETX
        mark();
        send_sym(8'hFE); send_sym(8'h05); send_sym(8'hAA); send_sym(8'hFE); send_sym(8'h40);
        idle(12);
        chk("short_ferr", n_ferr - b_ferr, 1);
        chk("short_no_done", n_done - b_done, 0);

        // Illegal escape, then a bare STX must be ignored in IDLE
        mark();
        send_sym(8'hFE); send_sym(8'h05); send_sym(8'h11); send_sym(8'hFE); send_sym(8'h22);
        idle(12);
        chk("esc_ferr", n_ferr - b_ferr, 1);
        mark(); send_sym(8'h05); idle(12);
        chk("idle_ignores_stx", n_init - b_init, 0);

        // Nested STX restart
        mark();
        send_sym(8'hFE); send_sym(8'h05); send_sym(8'h11); send_sym(8'hFE); send_sym(8'h05);
        q = {8'h22}; send_body(q, 8'h00); idle(12);
        chk("restart_ferr", n_ferr - b_ferr, 1);
        chk("restart_init", n_init - b_init, 2);
        chk("restart_ok", 32'(last_ok), 1);

        // rx_valid every third cycle
        gap_mode = 1;
        mark(); q = {8'h12, 8'h34}; send_pkt(q, 8'h00); idle(12);
        chk("slow_en", n_en - b_en, 24);
        chk("slow_ok", 32'(last_ok), 1);
        chk("slow_byte_cnt", 32'(byte_cnt), 2);
        gap_mode = 0;

        // Reset mid-DATA while a replay is running
        send_sym(8'hFE); send_sym(8'h05); send_sym(8'h12); send_sym(8'h34); send_sym(8'h56);
        send_sym(8'h78, 1'b1, 3);
        #1 chk("pre_reset_en", 32'(crc_en), 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_crc_en", 32'(crc_en), 0);
        chk("mid_rst_crc_bit", 32'(crc_bit), 0);
        chk("mid_rst_byte_cnt", 32'(byte_cnt), 0);
        chk("mid_rst_pkt_ok", 32'(pkt_ok), 0);
        chk("mid_rst_frame_err", 32'(frame_err), 0);
        mst = 0; pl.delete();
        s_init.delete(); s_en.delete(); s_bit.delete(); s_done.delete();
        s_ok.delete(); s_ferr.delete(); s_cnt.delete();
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        mark(); q = {8'h9C}; send_pkt(q, 8'h00); idle(12);
        chk("post_rst_ok", 32'(last_ok), 1);
        chk("post_rst_byte_cnt", 32'(byte_cnt), 1);

        // Length limit: 62 data + 2 CRC fits, 63 data overflows
        q.delete(); for (int i = 0; i < 62; i++) q.push_back(8'(i + 1));
        mark(); send_pkt(q, 8'h00); idle(12);
        chk("max_ok", 32'(last_ok), 1);
        chk("max_byte_cnt", 32'(byte_cnt), 62);
        q.push_back(8'h3F);
        mark(); send_pkt(q, 8'h00); idle(12);
        chk("over_ferr", n_ferr - b_ferr, 1);
        chk("over_no_done", n_done - b_done, 0);

        // Randomized traffic
        gap_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            q.delete();
            len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++)
                q.push_back(($urandom_range(0, 5) == 0) ? 8'hFE : 8'($urandom));
            if ($urandom_range(0, 4) == 0) send_sym(8'($urandom), ($urandom_range(0, 3) != 0));
            send_pkt(q, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            idle($urandom_range(1, 15));
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
